isqrt_pipe: RTL
===============

// Module: isqrt_pipe
// PURPOSE
// - Pipelined integer square root responder: y = floor(sqrt(x)), x 32-bit unsigned, y 16-bit.
// - Sits at top level next to formula FSMs; FSM drives x_vld/x and consumes y_vld/y.
// - Accepts one argument every cycle, no backpressure; results return in issue order after a fixed latency.
// PARAMETERS
// - BITS_PER_STAGE  default 1  result bits resolved per register stage; legal 1,2,4,8,16 (else $fatal at elaboration)
// - LATENCY (localparam) = 16 / BITS_PER_STAGE  clock edges from x accept to y_vld
// PORTS
// - clk    in   1   clock, all flops on posedge
// - rst    in   1   asynchronous, active-high reset
// - x_vld  in   1   argument valid; sampled every posedge
// - x      in   32  unsigned radicand; sampled when x_vld=1
// - y_vld  out  1   result valid, one-cycle pulse per accepted x
// - y      out  16  floor(sqrt(x)) of matching argument; 0 when no result has ever been produced
// - inflight out 5  (only with ISQRT_PIPE_INFLIGHT_EN) count of valid stages in pipe
// BEHAVIOUR
// - Reset: all stage valid bits, y_vld, y and inflight -> 0 immediately (async assert); released sync to clk.
// - Reset mid-operation: in-flight results discarded; no y_vld until a new x_vld arrives and LATENCY edges elapse.
// - Algorithm: digit-by-digit restoring sqrt, MSB first. Stage k carries {vld, remainder[33:0], root[15:0], x residual bits}.
//   Per resolved bit i (15..0): trial = (root<<2 | 1) compared with rem window; if rem_hi >= trial then
//   rem_hi -= trial, root = root<<1 | 1, else root = root<<1. Pure combinational chain of BITS_PER_STAGE bit-steps per stage.
// - Remainder width 18 bits minimum inside each step; no overflow for any 32-bit x (max root 0xFFFF).
// - Valid chain: vld[0] <= x_vld; vld[k] <= vld[k-1]; y_vld = vld[LATENCY-1] registered output. Data regs
//   advance every cycle regardless of vld (no enables); y updates only when final-stage vld=1, else holds last value.
// - Timing: x_vld=1 sampled at edge E0 -> y_vld=1 in cycle after edge E0+LATENCY-1, i.e. exactly LATENCY edges later.
// - Throughput 1/cycle; bubbles (x_vld=0) preserved position-exact at output; order strictly FIFO.
// - x ignored when x_vld=0 (any value, incl. X, must not disturb results of valid slots).
// - No state machine besides the valid shift chain; no stall input, consumer must accept every y_vld.
// CONFIGURATION
// - ISQRT_PIPE_INFLIGHT_EN defined: port inflight present; counter +1 on accept, -1 on y_vld emit,
//   unchanged when both or neither in same cycle; range 0..LATENCY; reset 0.
//   Also asserts (sim only) inflight never exceeds LATENCY.
// - Undefined: port absent, no counter logic; datapath and timing identical.
// TESTING
// - Corners, BITS_PER_STAGE=1: x=0->0, 1->1, 15->3, 16->4, 0xFFFFFFFF->0xFFFF, 0xFFFE0001->0xFFFF,
//   0xFFFE0000->0xFFFE; each y_vld exactly 16 edges after accept.
// - Back-to-back: x=4,9,25,100 on 4 consecutive cycles -> y=2,3,5,10 on 4 consecutive cycles, same order.
// - Bubbles: x_vld pattern 1,0,0,1,0,1 (x=49,_,_,144,_,1000000) -> y_vld pattern identical, y=7,12,1000.
// - Reset mid-flight: issue 8 values, assert rst 1 cycle after 5th edge -> y_vld stays 0 for all; new x=81 after
//   release -> y=9 after LATENCY edges; inflight (if enabled) 0 during reset.
// - Parameter sweep BITS_PER_STAGE=1,2,4,8,16: 10k random x vs reference $floor($sqrt) model, latency 16,8,4,2,1.
// - ISQRT_PIPE_INFLIGHT_EN: continuous stream 20 cycles -> inflight ramps 1..LATENCY and holds; stream stops -> drains to 0.

Source files
------------

// File: rtl/isqrt_pipe.sv
// Pipelined integer square root: y = floor(sqrt(x)), one argument per cycle, fixed latency 16/BITS_PER_STAGE.
// Optional occupancy counter port 'inflight' enabled by defining ISQRT_PIPE_INFLIGHT_EN.
module isqrt_pipe #(
  parameter int BITS_PER_STAGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
`ifdef ISQRT_PIPE_INFLIGHT_EN
  ,
  output logic [4:0]  inflight
`endif
);

  localparam int LATENCY = (BITS_PER_STAGE > 0) ? 16 / BITS_PER_STAGE : 1;
  // Remainder never exceeds 2*root (17 bits); two extra bits hold the shifted-in radicand pair.
  localparam int REM_W   = 20;

  generate
    if (!(BITS_PER_STAGE == 1 || BITS_PER_STAGE == 2 || BITS_PER_STAGE == 4 ||
          BITS_PER_STAGE == 8 || BITS_PER_STAGE == 16)) begin : g_bad_bps
      $fatal(1, "isqrt_pipe: BITS_PER_STAGE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef struct packed {
    logic [REM_W-1:0] rem;
    logic [15:0]      root;
    logic [31:0]      xres;
  } stage_t;

  function automatic stage_t sqrt_steps(input stage_t s);
    stage_t           o;
    logic [REM_W-1:0] win;
    logic [REM_W-1:0] trial;
    o = s;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      win    = {o.rem[REM_W-3:0], o.xres[31:30]};
      trial  = {{(REM_W-18){1'b0}}, o.root, 2'b01};
      o.xres = {o.xres[29:0], 2'b00};
      if (win >= trial) begin
        o.rem  = win - trial;
        o.root = {o.root[14:0], 1'b1};
      end else begin
        o.rem  = win;
        o.root = {o.root[14:0], 1'b0};
      end
    end
    return o;
  endfunction

  stage_t               w_in  [LATENCY];
  stage_t               w_out [LATENCY];
  stage_t               r_stage_p [LATENCY];
  logic   [LATENCY-1:0] r_vld_p;
  logic   [LATENCY:0]   w_vld_chain;
  logic   [15:0]        r_y;
  logic                 w_unused_tail;

  always_comb begin
    w_in[0] = '{rem: '0, root: '0, xres: x};
    for (int k = 1; k < LATENCY; k++) w_in[k] = r_stage_p[k-1];
    for (int k = 0; k < LATENCY; k++) w_out[k] = sqrt_steps(w_in[k]);
  end

  // Stage boundary: data registers, free-running with no reset or enable
  always_ff @(posedge clk) begin
    for (int k = 0; k < LATENCY; k++) r_stage_p[k] <= w_out[k];
  end

  // The last stage's root goes straight to y, so its stage register is never read.
  assign w_unused_tail = ^r_stage_p[LATENCY-1];

  assign w_vld_chain = {r_vld_p, x_vld};

  // Stage boundary: valid chain and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p <= '0;
      r_y     <= '0;
    end else begin
      r_vld_p <= w_vld_chain[LATENCY-1:0];
      if (w_vld_chain[LATENCY-1]) r_y <= w_out[LATENCY-1].root;
    end
  end

  assign y_vld = w_vld_chain[LATENCY];
  assign y     = r_y;

`ifdef ISQRT_PIPE_INFLIGHT_EN
  logic [4:0] r_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({x_vld, y_vld})
        2'b10:   r_inflight <= r_inflight + 5'd1;
        2'b01:   r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign inflight = r_inflight;

`ifndef SYNTHESIS
  a_inflight_max: assert property (@(posedge clk) disable iff (rst) r_inflight <= 5'(LATENCY));
`endif
`endif

endmodule
